time_keeper: RTL and testbench



---
 rtl/clock_pkg.sv | 28 ++
 rtl/bcd_field_counter.sv | 49 ++++
 rtl/time_keeper.sv | 84 ++++++++
 tb/tb_time_keeper.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared mode encoding and BCD field limits for the clock blocks
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_SEC  = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_HOUR = 2'd3
    } mode_e;

    localparam logic [3:0] SEC_MAX_TENS   = 4'd5;
    localparam logic [3:0] SEC_MAX_UNITS  = 4'd9;
    localparam logic [3:0] MIN_MAX_TENS   = 4'd5;
    localparam logic [3:0] MIN_MAX_UNITS  = 4'd9;
    localparam logic [3:0] HOUR_MAX_TENS  = 4'd2;
    localparam logic [3:0] HOUR_MAX_UNITS = 4'd3;

    // Mode button walks RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN
    function automatic mode_e next_mode(input mode_e m);
        case (m)
            MODE_RUN:      next_mode = MODE_SET_HOUR;
            MODE_SET_HOUR: next_mode = MODE_SET_MIN;
            MODE_SET_MIN:  next_mode = MODE_SET_SEC;
            default:       next_mode = MODE_RUN;
        endcase
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// rtl/bcd_field_counter.sv - two-digit BCD counter wrapping at TENS_MAX:UNITS_MAX
module bcd_field_counter #(
    parameter logic [3:0] TENS_MAX  = 4'd5,
    parameter logic [3:0] UNITS_MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       wrap
);

    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic       w_at_max;

    assign w_at_max = (r_tens == TENS_MAX) && (r_units == UNITS_MAX);
    // wrap is the carry into the next field; the caller decides whether to use it
    assign wrap  = inc & w_at_max;
    assign tens  = r_tens;
    assign units = r_units;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
        end else if (inc) begin
            if (w_at_max || (r_tens > TENS_MAX)) begin
                r_tens  <= 4'd0;
                r_units <= 4'd0;
            end else begin
                case (r_units)
                    4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                    4'd5, 4'd6, 4'd7, 4'd8: r_units <= r_units + 4'd1;
                    4'd9: begin
                        r_units <= 4'd0;
                        r_tens  <= r_tens + 4'd1;
                    end
                    default: begin
                        r_units <= 4'd0;
                        r_tens  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24h BCD time keeper with prescaler, button edge detect and set modes
module time_keeper
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_units,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [1:0] select_mode,
    output logic       sec_tick
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [2:0]    r_mode_sync;
    logic [2:0]    r_inc_sync;
    logic [PW-1:0] r_presc;
    logic          r_sec_tick;
    mode_e         r_mode;

    logic w_mode_pulse, w_inc_pulse, w_set_inc, w_tick;
    logic w_sec_inc, w_min_inc, w_hour_inc;
    logic w_sec_wrap, w_min_wrap, w_hour_wrap;

    assign w_mode_pulse = r_mode_sync[1] & ~r_mode_sync[2];
    assign w_inc_pulse  = r_inc_sync[1] & ~r_inc_sync[2];
    // A mode change in the same cycle swallows both an inc and a pending tick
    assign w_set_inc    = w_inc_pulse & ~w_mode_pulse;
    assign w_tick       = (r_mode == MODE_RUN) & ~w_mode_pulse & (r_presc == P_LAST);

    assign w_sec_inc  = w_tick | ((r_mode == MODE_SET_SEC) & w_set_inc);
    assign w_min_inc  = (w_tick & w_sec_wrap) | ((r_mode == MODE_SET_MIN) & w_set_inc);
    assign w_hour_inc = (w_tick & w_min_wrap) | ((r_mode == MODE_SET_HOUR) & w_set_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode_sync <= 3'b000;
            r_inc_sync  <= 3'b000;
            r_presc     <= '0;
            r_sec_tick  <= 1'b0;
            r_mode      <= MODE_RUN;
        end else begin
            r_mode_sync <= {r_mode_sync[1:0], mode_btn};
            r_inc_sync  <= {r_inc_sync[1:0], inc_btn};
            r_sec_tick  <= w_tick;
            if (w_mode_pulse) begin
                r_mode  <= next_mode(r_mode);
                r_presc <= '0;
            end else if (r_mode != MODE_RUN || r_presc == P_LAST) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    bcd_field_counter #(.TENS_MAX(SEC_MAX_TENS), .UNITS_MAX(SEC_MAX_UNITS)) u_sec (
        .clk(clk), .rst_n(rst_n), .inc(w_sec_inc),
        .tens(sec_tens), .units(sec_units), .wrap(w_sec_wrap)
    );

    bcd_field_counter #(.TENS_MAX(MIN_MAX_TENS), .UNITS_MAX(MIN_MAX_UNITS)) u_min (
        .clk(clk), .rst_n(rst_n), .inc(w_min_inc),
        .tens(min_tens), .units(min_units), .wrap(w_min_wrap)
    );

    bcd_field_counter #(.TENS_MAX(HOUR_MAX_TENS), .UNITS_MAX(HOUR_MAX_UNITS)) u_hour (
        .clk(clk), .rst_n(rst_n), .inc(w_hour_inc),
        .tens(hour_tens), .units(hour_units), .wrap(w_hour_wrap)
    );

    assign select_mode = r_mode;
    assign sec_tick    = r_sec_tick;

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units;
    logic [1:0] select_mode;
    logic       sec_tick;

    int tests = 0;
    int fails = 0;

    time_keeper #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .hour_tens(hour_tens), .hour_units(hour_units),
        .min_tens(min_tens), .min_units(min_units),
        .sec_tens(sec_tens), .sec_units(sec_units),
        .select_mode(select_mode), .sec_tick(sec_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] now_time();
        return {hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units};
    endfunction

    // which: 0 = mode, 1 = inc, 2 = both; effect is visible when the task returns
    task automatic press(input int which);
        repeat (3) @(posedge clk);
        #1;
        if (which != 1) mode_btn = 1'b1;
        if (which != 0) inc_btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic press_n(input int which, input int n);
        for (int i = 0; i < n; i++) press(which);
    endtask

    // Reset with the mode button already high, landing in SET_HOUR before any tick
    task automatic reset_into_set_hour();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mode_btn = 1'b1;
        inc_btn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mode_btn = 1'b0;
        tests++;
        if (select_mode !== 2'd3 || now_time() !== 24'h000000) begin
            fails++;
            $display("FAIL enter_set_hour: mode=%0d time=%h, want mode=3 time=000000", select_mode, now_time());
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (now_time() !== 24'h000000 || select_mode !== 2'd0 || sec_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: time=%h mode=%0d tick=%b, want 000000 0 0", now_time(), select_mode, sec_tick);
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sec_tick !== 1'b0 || now_time() !== 24'h000000) begin
            fails++;
            $display("FAIL reset_no_early_tick: tick=%b time=%h, want 0 000000", sec_tick, now_time());
        end
        @(posedge clk);
        #1;
        tests++;
        if (sec_tick !== 1'b1 || now_time() !== 24'h000001) begin
            fails++;
            $display("FAIL reset_first_tick: tick=%b time=%h, want 1 000001", sec_tick, now_time());
        end
        @(posedge clk);
        #1;
        tests++;
        if (sec_tick !== 1'b0) begin
            fails++;
            $display("FAIL tick_width: tick=%b, want 0", sec_tick);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sec_tick !== 1'b1 || now_time() !== 24'h000002) begin
            fails++;
            $display("FAIL tick_period: tick=%b time=%h, want 1 000002", sec_tick, now_time());
        end
    endtask

    task automatic test_rollover();
        reset_into_set_hour();
        press_n(1, 23);
        press(0);
        press_n(1, 59);
        press(0);
        press_n(1, 58);
        tests++;
        if (now_time() !== 24'h235958 || select_mode !== 2'd1) begin
            fails++;
            $display("FAIL rollover_setup: time=%h mode=%0d, want 235958 1", now_time(), select_mode);
        end
        press(0);
        tests++;
        if (select_mode !== 2'd0 || now_time() !== 24'h235958) begin
            fails++;
            $display("FAIL rollover_run: mode=%0d time=%h, want 0 235958", select_mode, now_time());
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (sec_tick !== 1'b1 || now_time() !== 24'h235959) begin
            fails++;
            $display("FAIL rollover_tick1: tick=%b time=%h, want 1 235959", sec_tick, now_time());
        end
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (sec_tick !== 1'b1 || now_time() !== 24'h000000) begin
            fails++;
            $display("FAIL rollover_tick2: tick=%b time=%h, want 1 000000", sec_tick, now_time());
        end
    endtask

    task automatic test_mode_cycle();
        logic [23:0] snap;
        logic        saw_tick;
        reset_into_set_hour();
        press(0);
        tests++;
        if (select_mode !== 2'd2) begin
            fails++;
            $display("FAIL mode_seq_min: mode=%0d, want 2", select_mode);
        end
        snap = now_time();
        saw_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (sec_tick) saw_tick = 1'b1;
        end
        tests++;
        if (saw_tick !== 1'b0 || now_time() !== snap) begin
            fails++;
            $display("FAIL set_frozen: tick_seen=%b time=%h, want 0 %h", saw_tick, now_time(), snap);
        end
        press(0);
        tests++;
        if (select_mode !== 2'd1) begin
            fails++;
            $display("FAIL mode_seq_sec: mode=%0d, want 1", select_mode);
        end
        press(0);
        tests++;
        if (select_mode !== 2'd0) begin
            fails++;
            $display("FAIL mode_seq_run: mode=%0d, want 0", select_mode);
        end
    endtask

    task automatic test_field_wrap();
        reset_into_set_hour();
        press_n(1, 5);
        press(0);
        press_n(1, 59);
        tests++;
        if (now_time() !== 24'h055900) begin
            fails++;
            $display("FAIL min_at_59: time=%h, want 055900", now_time());
        end
        press(1);
        tests++;
        if (now_time() !== 24'h050000) begin
            fails++;
            $display("FAIL min_wrap: time=%h, want 050000", now_time());
        end
        reset_into_set_hour();
        press_n(1, 23);
        tests++;
        if (now_time() !== 24'h230000) begin
            fails++;
            $display("FAIL hour_at_23: time=%h, want 230000", now_time());
        end
        press(1);
        tests++;
        if (now_time() !== 24'h000000) begin
            fails++;
            $display("FAIL hour_wrap: time=%h, want 000000", now_time());
        end
    endtask

    task automatic test_simultaneous();
        reset_into_set_hour();
        press_n(1, 2);
        press(2);
        tests++;
        if (select_mode !== 2'd2 || now_time() !== 24'h020000) begin
            fails++;
            $display("FAIL simultaneous: mode=%0d time=%h, want 2 020000", select_mode, now_time());
        end
    endtask

    task automatic test_latency_hold();
        reset_into_set_hour();
        press(0);
        press(0);
        repeat (3) @(posedge clk);
        #1;
        inc_btn = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (sec_units !== 4'd0) begin
            fails++;
            $display("FAIL latency_edge1: sec_units=%0d, want 0", sec_units);
        end
        @(posedge clk);
        #1;
        tests++;
        if (sec_units !== 4'd0) begin
            fails++;
            $display("FAIL latency_edge2: sec_units=%0d, want 0", sec_units);
        end
        @(posedge clk);
        #1;
        tests++;
        if (sec_units !== 4'd1) begin
            fails++;
            $display("FAIL latency_edge3: sec_units=%0d, want 1", sec_units);
        end
        repeat (17) @(posedge clk);
        #1;
        inc_btn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (now_time() !== 24'h000001 || select_mode !== 2'd1) begin
            fails++;
            $display("FAIL hold_single_inc: time=%h mode=%0d, want 000001 1", now_time(), select_mode);
        end
    endtask

    initial begin
        test_reset();
        test_rollover();
        test_mode_cycle();
        test_field_wrap();
        test_simultaneous();
        test_latency_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
